// File: rtl/dino_game_ctrl.sv
// rtl/dino_game_ctrl.sv - game FSM driving start/over/tick pulses into the score counter
// Button and collision are synchronised; the button is debounced before it can start a game.
module dino_game_ctrl #(
    parameter int TICK_DIV     = 833_333,
    parameter int DEBOUNCE_CYC = 16,
    parameter int OVER_HOLD    = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        collision,
    output logic        game_start,
    output logic        game_over,
    output logic        game_tick,
    output logic [1:0]  state,
    output logic [15:0] frame_cnt
);
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(OVER_HOLD);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_RUN   = 2'b10,
        S_OVER  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              btn_s1_q, btn_s2_q, col_s1_q, col_s2_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              deb_lvl_q, deb_lvl_d, deb_dly_q, press_q;
    logic [DIV_W-1:0]  div_q, div_d, div_nxt;
    logic              tick_evt;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              start_q, start_d, over_q, over_d, tick_q, tick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            col_s1_q  <= 1'b0;
            col_s2_q  <= 1'b0;
            deb_cnt_q <= '0;
            deb_lvl_q <= 1'b0;
            deb_dly_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            btn_s1_q  <= btn_start;
            btn_s2_q  <= btn_s1_q;
            col_s1_q  <= collision;
            col_s2_q  <= col_s1_q;
            deb_cnt_q <= deb_cnt_d;
            deb_lvl_q <= deb_lvl_d;
            deb_dly_q <= deb_lvl_q;
            press_q   <= deb_lvl_q & ~deb_dly_q;
        end
    end

    // Any cycle where the synced level agrees with the accepted level restarts the count.
    always_comb begin
        deb_cnt_d = '0;
        deb_lvl_d = deb_lvl_q;
        if (btn_s2_q != deb_lvl_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_lvl_d = btn_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign div_nxt  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    assign tick_evt = (div_nxt == DIV_LAST);

    always_comb begin
        state_d     = state_q;
        div_d       = '0;
        hold_d      = '0;
        frame_cnt_d = frame_cnt_q;
        start_d     = 1'b0;
        over_d      = 1'b0;
        tick_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_q) begin
                    state_d     = S_START;
                    start_d     = 1'b1;
                    frame_cnt_d = '0;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                div_d = div_nxt;
                // Collision wins over a coinciding tick so the final frame is not scored.
                if (col_s2_q) begin
                    state_d = S_OVER;
                    over_d  = 1'b1;
                end else if (tick_evt) begin
                    tick_d = 1'b1;
                    if (frame_cnt_q != 16'hFFFF) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            S_OVER: begin
                div_d  = div_nxt;
                hold_d = hold_q;
                if (tick_evt && hold_q != HOLD_DONE) begin
                    hold_d = hold_q + 1'b1;
                end
                if (press_q && hold_q == HOLD_DONE) begin
                    state_d     = S_START;
                    start_d     = 1'b1;
                    frame_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            hold_q      <= '0;
            frame_cnt_q <= '0;
            start_q     <= 1'b0;
            over_q      <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            hold_q      <= hold_d;
            frame_cnt_q <= frame_cnt_d;
            start_q     <= start_d;
            over_q      <= over_d;
            tick_q      <= tick_d;
        end
    end

    assign game_start = start_q;
    assign game_over  = over_q;
    assign game_tick  = tick_q;
    assign state      = state_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb/tb_dino_game_ctrl.sv - directed and randomized bench for dino_game_ctrl
// Reference model works in edge numbers: ticks fall on edges start+n*TICK_DIV.
module tb_dino_game_ctrl;
    localparam int TD = 10;
    localparam int DB = 4;
    localparam int OH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0;
    logic        collision = 1'b0;
    logic        game_start, game_over, game_tick;
    logic [1:0]  state;
    logic [15:0] frame_cnt;

    dino_game_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DB), .OVER_HOLD(OH)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .collision(collision),
        .game_start(game_start), .game_over(game_over), .game_tick(game_tick),
        .state(state), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int edge_n = 0;
    bit btn_h[4];
    bit col_h[4];
    int m_state = 0;
    int m_level = 0, m_run = 0, rise_e = -100, start_e = 0, over_e = 0;
    int m_frame = 0;
    bit e_start = 0, e_over = 0, e_tick = 0;

    task automatic model_step();
        int k;
        bit sb, sc, press;
        k = edge_n;
        if (rst) begin
            btn_h[k & 3] = 1'b0;
            col_h[k & 3] = 1'b0;
            m_state = 0; m_level = 0; m_run = 0; rise_e = -100; m_frame = 0;
            e_start = 0; e_over = 0; e_tick = 0;
        end else begin
            btn_h[k & 3] = btn_start;
            col_h[k & 3] = collision;
            sb = (k >= 2) ? btn_h[(k - 2) & 3] : 1'b0;
            sc = (k >= 2) ? col_h[(k - 2) & 3] : 1'b0;
            press = (rise_e == k - 2);
            if (int'(sb) != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = int'(sb);
                    m_run = 0;
                    if (sb) rise_e = k;
                end
            end else begin
                m_run = 0;
            end
            e_start = 0; e_over = 0; e_tick = 0;
            case (m_state)
                0: if (press) begin m_state = 1; e_start = 1; start_e = k; m_frame = 0; end
                1: m_state = 2;
                2: begin
                    if (sc) begin
                        m_state = 3; e_over = 1; over_e = k;
                    end else if ((k - start_e) % TD == 0) begin
                        e_tick = 1;
                        if (m_frame < 65535) m_frame++;
                    end
                end
                default: begin
                    if (press && ((k - 1 - start_e) / TD - (over_e - start_e) / TD) >= OH) begin
                        m_state = 1; e_start = 1; start_e = k; m_frame = 0;
                    end
                end
            endcase
        end
        edge_n++;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("game_start", 32'(game_start), 32'(e_start));
        check_eq("game_over", 32'(game_over), 32'(e_over));
        check_eq("game_tick", 32'(game_tick), 32'(e_tick));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        check_eq("pulse_excl", 32'(int'(game_start) + int'(game_over) + int'(game_tick) <= 1), 32'd1);
    endtask

    initial begin
        int gs_at, gs_n, tk_n, st8, found, b_left, c_left;
        int tk_at[3];

        repeat (3) step();
        check_eq("reset_state", 32'(state), 32'd0);
        check_eq("reset_frame", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        repeat (3) step();

        // Short glitch must not start a game
        btn_start = 1'b1;
        repeat (3) step();
        btn_start = 1'b0;
        repeat (12) step();
        check_eq("glitch_idle", 32'(state), 32'd0);

        // Held press: start at cycle 7, ticks at 17/27/37
        btn_start = 1'b1;
        gs_at = -1; gs_n = 0; tk_n = 0; st8 = -1;
        tk_at[0] = -1; tk_at[1] = -1; tk_at[2] = -1;
        for (int i = 0; i < 38; i++) begin
            step();
            if (game_start) begin gs_n++; if (gs_at < 0) gs_at = i; end
            if (i == 8) st8 = int'(state);
            if (game_tick) begin if (tk_n < 3) tk_at[tk_n] = i; tk_n++; end
        end
        check_eq("start_cycle", 32'(gs_at), 32'd7);
        check_eq("start_once", 32'(gs_n), 32'd1);
        check_eq("run_at_8", 32'(st8), 32'd2);
        check_eq("tick1_cycle", 32'(tk_at[0]), 32'd17);
        check_eq("tick2_cycle", 32'(tk_at[1]), 32'd27);
        check_eq("tick3_cycle", 32'(tk_at[2]), 32'd37);
        check_eq("frame_at_37", 32'(frame_cnt), 32'd3);
        btn_start = 1'b0;

        // Collision landing on the divider wrap edge
        repeat (TD - 3) step();
        collision = 1'b1;
        repeat (2) step();
        collision = 1'b0;
        step();
        check_eq("coll_over", 32'(game_over), 32'd1);
        check_eq("coll_no_tick", 32'(game_tick), 32'd0);
        check_eq("coll_frame", 32'(frame_cnt), 32'd3);
        check_eq("coll_state", 32'(state), 32'd3);

        // Early press in OVER ignored, later press restarts
        btn_start = 1'b1;
        repeat (10) step();
        btn_start = 1'b0;
        repeat (13) step();
        check_eq("hold_ignore", 32'(state), 32'd3);
        repeat (10) step();
        btn_start = 1'b1;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            step();
            if (game_start) begin
                found = 1;
                check_eq("restart_frame", 32'(frame_cnt), 32'd0);
            end
        end
        check_eq("restart_seen", 32'(found), 32'd1);
        btn_start = 1'b0;

        // Saturation of frame_cnt
        found = 0;
        for (int i = 0; i < 3 * TD && found == 0; i++) begin
            step();
            if (game_tick) found = 1;
        end
        check_eq("sat_first_tick", 32'(found), 32'd1);
        force dut.frame_cnt_q = 16'hFFFE;
        m_frame = 16'hFFFE;
        step();
        release dut.frame_cnt_q;
        tk_n = 0;
        for (int i = 0; i < 4 * TD && tk_n < 3; i++) begin
            step();
            if (game_tick) tk_n++;
        end
        check_eq("sat_ticks", 32'(tk_n), 32'd3);
        check_eq("sat_frame", 32'(frame_cnt), 32'hFFFF);

        // Asynchronous reset mid-RUN
        #2 rst = 1'b1;
        #1;
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_frame", 32'(frame_cnt), 32'd0);
        check_eq("arst_pulses", 32'({game_start, game_over, game_tick}), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        gs_n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (game_start || game_tick || game_over) gs_n++;
        end
        check_eq("post_rst_quiet", 32'(gs_n), 32'd0);

        // Randomized traffic
        b_left = 0; c_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (b_left == 0) begin
                btn_start = 1'($urandom_range(0, 1));
                b_left = int'($urandom_range(1, 14));
            end
            b_left--;
            if (c_left == 0) begin
                collision = ($urandom_range(0, 5) == 0);
                c_left = collision ? int'($urandom_range(1, 3)) : int'($urandom_range(10, 80));
            end
            c_left--;
            rst = ($urandom_range(0, 799) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
